// File: rtl/rv2t_reg_file_seq.sv
// RV2T register-file access controller for a single BRAM: serializes rs1/rs2 onto
// one synchronous read port, forwards in-flight writes and shares the RAM with debug.
module rv2t_reg_file_seq #(
    parameter int REG_ADDR_BITS = 5,
    parameter int XLEN          = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     read_enable,
    input  logic [REG_ADDR_BITS-1:0] read_rs1_addr,
    input  logic [REG_ADDR_BITS-1:0] read_rs2_addr,
    output logic                     read_ready,
    output logic                     read_en_out,
    output logic [XLEN-1:0]          read_rs1_data_out,
    output logic [XLEN-1:0]          read_rs2_data_out,
    input  logic                     write_enable,
    input  logic [REG_ADDR_BITS-1:0] write_addr,
    input  logic [XLEN-1:0]          write_data_in,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    input  logic [XLEN-1:0]          dbg_wdata,
    output logic                     dbg_ack,
    output logic [XLEN-1:0]          dbg_rdata,
    output logic [REG_ADDR_BITS-1:0] ram_raddr,
    input  logic [XLEN-1:0]          ram_rdata,
    output logic                     ram_we,
    output logic [REG_ADDR_BITS-1:0] ram_waddr,
    output logic [XLEN-1:0]          ram_wdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD2  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DBG  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [REG_ADDR_BITS-1:0] r_rs1_addr;
    logic [REG_ADDR_BITS-1:0] r_rs2_addr;
    logic [REG_ADDR_BITS-1:0] r_dbg_addr;
    logic [XLEN-1:0]          r_rs1_data;
    logic [XLEN-1:0]          r_rs2_data;
    logic [XLEN-1:0]          r_dbg_rdata;
    logic                     r_dbg_ack;
    // Previous cycle's effective write: the RAM returns old data on a collision
    logic                     r_e_vld;
    logic [REG_ADDR_BITS-1:0] r_e_addr;
    logic [XLEN-1:0]          r_e_data;

    logic                     w_ready;
    logic                     w_rd_acc;
    logic                     w_dbg_rd_start;
    logic                     w_dbg_wr;
    logic                     w_e_vld;
    logic [REG_ADDR_BITS-1:0] w_e_addr;
    logic [XLEN-1:0]          w_e_data;
    logic [XLEN-1:0]          w_rs1_res;
    logic [XLEN-1:0]          w_rs2_res;
    logic [XLEN-1:0]          w_dbg_res;

    assign w_ready        = (r_state == S_IDLE) || (r_state == S_OUT);
    assign w_rd_acc       = w_ready && read_enable;
    assign w_dbg_rd_start = w_ready && dbg_req && !dbg_we && !read_enable && !r_dbg_ack;
    assign w_dbg_wr       = dbg_req && dbg_we && !write_enable && !r_dbg_ack;

    assign w_e_vld  = write_enable || w_dbg_wr;
    assign w_e_addr = write_enable ? write_addr    : dbg_addr;
    assign w_e_data = write_enable ? write_data_in : dbg_wdata;

    assign ram_we    = w_e_vld && (w_e_addr != '0);
    assign ram_waddr = w_e_addr;
    assign ram_wdata = w_e_data;

    always_comb begin
        ram_raddr = read_enable ? read_rs1_addr : dbg_addr;
        if (r_state == S_RD2) ram_raddr = r_rs2_addr;
    end

    // rs1 and debug reads were issued one cycle ago: the current write is newer
    // than the delayed one, so it is checked first.
    assign w_rs1_res = (r_rs1_addr == '0)                      ? '0       :
                       (w_e_vld && (w_e_addr == r_rs1_addr))   ? w_e_data :
                       (r_e_vld && (r_e_addr == r_rs1_addr))   ? r_e_data : ram_rdata;

    assign w_dbg_res = (r_dbg_addr == '0)                      ? '0       :
                       (w_e_vld && (w_e_addr == r_dbg_addr))   ? w_e_data :
                       (r_e_vld && (r_e_addr == r_dbg_addr))   ? r_e_data : ram_rdata;

    // rs2 is read in RD2, so only the RD2 write can be missing from the RAM data
    assign w_rs2_res = (r_rs2_addr == '0)                      ? '0       :
                       (r_e_vld && (r_e_addr == r_rs2_addr))   ? r_e_data : ram_rdata;

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE, S_OUT: begin
                if (w_rd_acc)            w_state_nxt = S_RD2;
                else if (w_dbg_rd_start) w_state_nxt = S_DBG;
            end
            S_RD2:   w_state_nxt = S_OUT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_dbg_addr  <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_dbg_rdata <= '0;
            r_dbg_ack   <= 1'b0;
            r_e_vld     <= 1'b0;
            r_e_addr    <= '0;
            r_e_data    <= '0;
        end else if (sync_reset) begin
            r_state     <= S_IDLE;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_dbg_addr  <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_dbg_rdata <= '0;
            r_dbg_ack   <= 1'b0;
            r_e_vld     <= 1'b0;
            r_e_addr    <= '0;
            r_e_data    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_e_vld  <= w_e_vld;
            r_e_addr <= w_e_addr;
            r_e_data <= w_e_data;
            if (w_rd_acc) begin
                r_rs1_addr <= read_rs1_addr;
                r_rs2_addr <= read_rs2_addr;
            end
            if (w_dbg_rd_start)     r_dbg_addr  <= dbg_addr;
            if (r_state == S_RD2)   r_rs1_data  <= w_rs1_res;
            if (r_state == S_OUT)   r_rs2_data  <= w_rs2_res;
            if (r_state == S_DBG)   r_dbg_rdata <= w_dbg_res;
            r_dbg_ack <= w_dbg_wr || (r_state == S_DBG);
        end
    end

    assign read_ready        = w_ready;
    assign read_en_out       = (r_state == S_OUT);
    assign read_rs1_data_out = r_rs1_data;
    // rs2 is live from the RAM in OUT and held from the register afterwards
    assign read_rs2_data_out = (r_state == S_OUT) ? w_rs2_res : r_rs2_data;
    assign dbg_ack           = r_dbg_ack;
    assign dbg_rdata         = r_dbg_rdata;

endmodule

// File: tb/tb_rv2t_reg_file_seq.sv
// Bench for rv2t_reg_file_seq: RAM model plus an architectural register model
// (expected operands = register contents at the start of the result cycle).
module tb_rv2t_reg_file_seq;

    logic        clk = 1'b0;
    logic        reset_n, sync_reset;
    logic        read_enable;
    logic [4:0]  read_rs1_addr, read_rs2_addr;
    logic        read_ready, read_en_out;
    logic [31:0] read_rs1_data_out, read_rs2_data_out;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data_in;
    logic        dbg_req, dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [4:0]  ram_raddr;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic [4:0]  ram_waddr;
    logic [31:0] ram_wdata;

    always #5 clk = ~clk;

    rv2t_reg_file_seq #(.REG_ADDR_BITS(5), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .read_enable(read_enable), .read_rs1_addr(read_rs1_addr), .read_rs2_addr(read_rs2_addr),
        .read_ready(read_ready), .read_en_out(read_en_out),
        .read_rs1_data_out(read_rs1_data_out), .read_rs2_data_out(read_rs2_data_out),
        .write_enable(write_enable), .write_addr(write_addr), .write_data_in(write_data_in),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    // Synchronous-read RAM, old data on a same-address collision
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] arch [0:31];
    int          cnum = 0;
    int          m_rd_at, m_nr_at, m_ack_at;
    logic [4:0]  m_a1, m_a2, m_dbg_a;
    logic        m_dbg_rd;
    logic [31:0] m_h1, m_h2;
    logic        ack_seen, acc_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_rd_at = -10; m_nr_at = -10; m_ack_at = -10;
        m_dbg_rd = 1'b0; m_h1 = '0; m_h2 = '0;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, move to the next cycle.
    // kind 1: constant operand check, kind 2: debug-read ack with data c1, kind 3: ack only.
    task automatic step(input int kind = 0, input logic [31:0] c1 = 0, input logic [31:0] c2 = 0);
        logic exp_ready, exp_en, exp_ack, acc, drd, wiss, we_exp;
        logic [4:0]  wa;
        logic [31:0] wd;
        @(negedge clk);
        if (!reset_n) model_clear();
        exp_ready = (cnum != m_nr_at);
        exp_en    = (cnum == m_rd_at);
        exp_ack   = (cnum == m_ack_at);
        acc  = reset_n && exp_ready && read_enable;
        drd  = reset_n && exp_ready && dbg_req && !dbg_we && !read_enable && !exp_ack;
        wiss = dbg_req && dbg_we && !write_enable && !exp_ack;
        wa   = write_enable ? write_addr : dbg_addr;
        wd   = write_enable ? write_data_in : dbg_wdata;
        we_exp = (write_enable || wiss) && (wa != 5'd0);
        if (exp_en) begin
            m_h1 = arch[m_a1];
            m_h2 = arch[m_a2];
        end
        chk1("read_ready", read_ready, exp_ready);
        chk1("read_en_out", read_en_out, exp_en);
        chk("rs1_data", read_rs1_data_out, m_h1);
        chk("rs2_data", read_rs2_data_out, m_h2);
        chk1("dbg_ack", dbg_ack, exp_ack);
        if (exp_ack && m_dbg_rd) chk("dbg_rdata", dbg_rdata, arch[m_dbg_a]);
        if (!reset_n) chk("dbg_rdata_rst", dbg_rdata, 32'h0);
        chk1("ram_we", ram_we, we_exp);
        if (we_exp) begin
            chk("ram_waddr", {27'b0, ram_waddr}, {27'b0, wa});
            chk("ram_wdata", ram_wdata, wd);
        end
        if (acc)                                          chk("raddr_rs1", {27'b0, ram_raddr}, {27'b0, read_rs1_addr});
        else if (cnum == m_nr_at && m_rd_at == cnum + 1) chk("raddr_rs2", {27'b0, ram_raddr}, {27'b0, m_a2});
        else if (drd)                                     chk("raddr_dbg", {27'b0, ram_raddr}, {27'b0, dbg_addr});
        if (kind == 1) begin
            chk1("const_en", read_en_out, 1'b1);
            chk("const_rs1", read_rs1_data_out, c1);
            chk("const_rs2", read_rs2_data_out, c2);
        end else if (kind == 2) begin
            chk1("const_ack", dbg_ack, 1'b1);
            chk("const_dbg_rdata", dbg_rdata, c1);
        end else if (kind == 3) begin
            chk1("const_wr_ack", dbg_ack, 1'b1);
        end
        if (we_exp) arch[wa] = wd;
        if (reset_n && !sync_reset) begin
            if (acc) begin
                m_rd_at = cnum + 2; m_nr_at = cnum + 1;
                m_a1 = read_rs1_addr; m_a2 = read_rs2_addr;
            end
            if (drd) begin
                m_ack_at = cnum + 2; m_nr_at = cnum + 1;
                m_dbg_rd = 1'b1; m_dbg_a = dbg_addr;
            end
            if (wiss) begin
                m_ack_at = cnum + 1; m_dbg_rd = 1'b0;
            end
        end else if (sync_reset) begin
            model_clear();
        end
        ack_seen = exp_ack;
        acc_seen = acc && !sync_reset;
        cnum++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        write_enable = en; write_addr = a; write_data_in = d;
    endtask

    task automatic rd(input logic en, input logic [4:0] a1, input logic [4:0] a2);
        read_enable = en; read_rs1_addr = a1; read_rs2_addr = a2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) arch[i] = '0;
        model_clear();
        ack_seen = 1'b0; acc_seen = 1'b0;
        reset_n = 1'b0; sync_reset = 1'b0;
        rd(0, 0, 0); wr(0, 0, 0);
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        step(); step();
        reset_n = 1'b1;
        step();

        // Preload every register through the pipeline write port
        for (int i = 1; i < 32; i++) begin
            wr(1, 5'(i), (i == 5) ? 32'h11 : (i == 6) ? 32'h22 : (i == 7) ? 32'h77 : $urandom);
            step();
        end
        wr(0, 0, 0);

        // Plain read x5/x6
        rd(1, 5, 6); step();
        rd(0, 0, 0); step();
        step(1, 32'h11, 32'h22);

        // Writes at T and T+1 to the read register: latest wins on both operands
        rd(1, 5, 5); wr(1, 5, 32'hAA); step();
        rd(0, 0, 0); wr(1, 5, 32'hBB); step();
        wr(0, 0, 0); step(1, 32'hBB, 32'hBB);

        // rs1 via the delayed forward; a write in the result cycle is not seen
        rd(1, 5, 6); wr(1, 5, 32'h55); step();
        rd(0, 0, 0); wr(0, 0, 0); step();
        wr(1, 6, 32'hCC); step(1, 32'h55, 32'h22);
        wr(0, 0, 0);

        // x0: writes suppressed, reads return zero
        wr(1, 0, 32'hFFFF_FFFF); step();
        rd(1, 0, 0); step();
        rd(0, 0, 0); wr(0, 0, 0); step();
        step(1, 32'h0, 32'h0);

        // Back-to-back reads accepted at T and T+2
        rd(1, 6, 7); step();
        rd(0, 0, 0); step();
        rd(1, 5, 6); step(1, 32'hCC, 32'h77);
        rd(0, 0, 0); step();
        step(1, 32'h55, 32'hCC);

        // Debug read of x7
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7; step();
        step();
        step(2, 32'h77);
        dbg_req = 1'b0; step();

        // Debug read waits for the concurrent pipeline read to be accepted
        dbg_req = 1'b1; rd(1, 5, 6); step();
        rd(0, 0, 0); step();
        step(1, 32'h55, 32'hCC);
        step();
        step(2, 32'h77);
        dbg_req = 1'b0; step();

        // Debug write blocked by three pipeline writes, then issues and acks
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h5A;
        for (int i = 0; i < 3; i++) begin
            wr(1, 3, $urandom); step();
        end
        wr(0, 0, 0); step();
        step(3);
        dbg_req = 1'b0; dbg_we = 1'b0; step();
        rd(1, 9, 0); step();
        rd(0, 0, 0); step();
        step(1, 32'h5A, 32'h0);

        // Asynchronous reset during RD2 abandons the read
        rd(1, 5, 6); step();
        rd(0, 0, 0); reset_n = 1'b0; step();
        reset_n = 1'b1; step();
        step(); step();

        // Randomized traffic with requesters that hold until served
        for (int n = 0; n < 1500; n++) begin
            if (!(read_enable && !acc_seen))
                rd(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            wr(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            if (!dbg_req || ack_seen) begin
                dbg_req   = ($urandom_range(0, 3) == 0);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 5'($urandom_range(0, 7));
                dbg_wdata = $urandom;
            end
            sync_reset = ($urandom_range(0, 99) == 0);
            step();
        end
        sync_reset = 1'b0; rd(0, 0, 0); wr(0, 0, 0); dbg_req = 1'b0;
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
